im_prefetch: RTL and testbench
==============================

# im_prefetch

Sequential instruction prefetch buffer that sits between the instruction-cache miss port of the single-cycle datapath and the external instruction memory. It keeps up to DEPTH consecutive instruction words ahead of the last served address, so that sequential i-cache refills are served in one cycle. Non-sequential requests redirect the stream. The block has one outstanding memory transaction at most and presents the same request/ready handshake on both sides.

## Interface
- DEPTH, 4: buffer entries; power of two, ≥2.
- PC_RESET, `PC_RESET: initial stream address after reset.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  CPU-side word request; held with i_addr until o_ready.
- i_addr  in  `XLEN  requested byte address; bits [1:0] ignored.
- i_flush  in  1  discard all buffered and in-flight words (fence.i).
- o_data  out  `XLEN  returned word; valid while o_ready=1.
- o_ready  out  1  one-cycle pulse, request served.
- o_mem_req  out  1  memory request; held with o_mem_addr until i_mem_ready.
- o_mem_addr  out  `XLEN  word-aligned fetch address.
- i_mem_data  in  `XLEN  memory word; sampled when i_mem_ready=1.
- i_mem_ready  in  1  memory completion, one cycle.

## Operation
- State: head_addr (address of oldest buffered word), count (0..DEPTH), fetch_addr = head_addr + 4·(count + in-flight), FSM {IDLE, FETCH, DISCARD}.
- Hit: i_req, count>0, i_addr[XLEN-1:2]==head_addr[XLEN-1:2] → o_data=head word, o_ready pulse, pop, head_addr+=4.
- Pending hit: i_req, count==0, FETCH in flight for i_addr → serve from i_mem_data on completion; word is not stored.
- Miss: any other i_req → head_addr=i_addr&~3, count=0. From IDLE → FETCH at i_addr. From FETCH → DISCARD; in-flight word is dropped on completion, then FETCH at head_addr.
- Prefetch: IDLE with count<DEPTH and no pending miss → FETCH at fetch_addr.
- FETCH→IDLE on i_mem_ready; word pushed at tail unless consumed by pending hit.
- i_req is ignored in the cycle o_ready=1.
- i_flush: count=0. If FETCH, go to DISCARD. Stream restarts at the next i_req (miss path). i_flush with i_req in the same cycle: flush first, request treated as a miss.
- Pop and push in the same cycle: count unchanged.
- Full (count==DEPTH): no new fetch issued.
- Address arithmetic is modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0.
- Reset values: o_ready=0, o_mem_req=0, o_mem_addr=PC_RESET, o_data=0, count=0, head_addr=PC_RESET, state IDLE.
- Reset mid-transaction drops o_mem_req immediately; the memory side must tolerate the abandoned request.

## Timing
- All outputs are registered.
- Hit: i_req sampled at edge N → o_ready=1 during cycle N..N+1. Latency is one cycle.
- Miss from IDLE: i_req at edge N → o_mem_req=1 from N. If i_mem_ready is sampled at edge M → o_ready at M (cycle after M). Latency = memory latency + 1.
- Miss during FETCH: the in-flight fetch completes first, then the new fetch issues at the following edge.
- Prefetch: the next fetch issues at the edge after i_mem_ready. Back-to-back memory requests have a one-cycle gap.
- o_mem_addr is stable for the entire time o_mem_req=1.

## Structure
- FSM state encodings and the DEPTH minimum check go in arvi_defines.vh as `IMPF_IDLE/`IMPF_FETCH/`IMPF_DISCARD.
- Storage is a sub-module, fifo_sync (DEPTH×`XLEN, push/pop/count, simultaneous push+pop, synchronous clear, async active-low reset).
- im_prefetch holds the FSM, the address registers and the hit/miss comparison.

## Test plan
- Reset, then i_req@0x0, memory latency 2 → o_mem_addr=0x0; o_ready 3 cycles after the request with o_data=mem[0x0]; buffer then fills 0x4..0x10 (count=4) and no further fetch is issued.
- Full buffer, sequential i_req 0x4,0x8,0xC,0x10 → each o_ready exactly one cycle after its request; 0x14 fetch issued after the first pop.
- i_req@0x100 while a fetch for 0x14 is in flight → 0x14 data discarded; next o_mem_addr=0x100; o_data=mem[0x100].
- Same-cycle pop and fill at count=2 → count stays 2; served words match memory order.
- i_flush during FETCH, then i_req@0x8 → in-flight word dropped; refetch at 0x8; no stale word returned.
- Stream at 0xFFFF_FFF8 → prefetch addresses 0xFFFF_FFFC, 0x0000_0000; hit on 0x0 correct. Async reset asserted mid-FETCH → o_mem_req=0 and o_ready=0 in the same cycle.

Source files
------------

// File: rtl/im_prefetch_pkg.sv
// Shared constants for the instruction prefetch buffer: word width, FSM encodings
// and address helpers.
package im_prefetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] IMPF_IDLE    = 2'd0;
  localparam logic [1:0] IMPF_FETCH   = 2'd1;
  localparam logic [1:0] IMPF_DISCARD = 2'd2;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

  function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
    return addr + XLEN'(4);
  endfunction

endpackage

// File: rtl/im_prefetch_fifo_sync.sv
// Synchronous FIFO holding prefetched words; supports push and pop in the same cycle
// and a synchronous clear that overrides both.
module im_prefetch_fifo_sync #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;
  logic             full;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/im_prefetch.sv
// Sequential instruction prefetch buffer between the i-cache miss port and instruction
// memory: serves sequential words from a small FIFO and redirects on non-sequential requests.
module im_prefetch
  import im_prefetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_data,
  output logic            o_ready,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_mem_ready
);

  localparam int unsigned  CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("im_prefetch: DEPTH must be a power of two and at least 2");
  end

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] head_q, head_d;
  logic            stream_q, stream_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;

  logic            fifo_push, fifo_pop, fifo_clr;
  logic [XLEN-1:0] fifo_rdata;
  logic [CW-1:0]   fifo_count;

  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] fetch_addr;
  logic            serve_ok, hit, pend, miss;

  im_prefetch_fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .wdata (i_mem_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign req_addr   = word_align(i_addr);
  assign fetch_addr = head_q + (XLEN'(fifo_count) << 2);

  // A request is not re-evaluated in the cycle its previous service is presented.
  assign serve_ok = i_req && !ready_q;
  assign hit      = serve_ok && !i_flush && (fifo_count != '0) &&
                    (i_addr[XLEN-1:2] == head_q[XLEN-1:2]);
  assign pend     = serve_ok && !i_flush && (fifo_count == '0) && (state_q == IMPF_FETCH) &&
                    (i_addr[XLEN-1:2] == mem_addr_q[XLEN-1:2]);
  assign miss     = serve_ok && !hit && !pend;

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    stream_d   = stream_q;
    ready_d    = 1'b0;
    data_d     = data_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clr   = 1'b0;

    // Flush parks the stream until the next request restarts it via the miss path.
    if (i_flush) begin
      fifo_clr = 1'b1;
      stream_d = 1'b0;
    end
    if (hit) begin
      ready_d  = 1'b1;
      data_d   = fifo_rdata;
      fifo_pop = 1'b1;
      head_d   = next_word(head_q);
    end
    if (miss) begin
      head_d   = req_addr;
      fifo_clr = 1'b1;
      stream_d = 1'b1;
    end

    case (state_q)
      IMPF_IDLE: begin
        if (miss) begin
          state_d    = IMPF_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = req_addr;
        end else if (stream_q && !i_flush && (fifo_count != FULL)) begin
          state_d    = IMPF_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_addr;
        end
      end
      IMPF_FETCH: begin
        if (i_mem_ready) begin
          state_d   = IMPF_IDLE;
          mem_req_d = 1'b0;
          if (pend) begin
            ready_d = 1'b1;
            data_d  = i_mem_data;
            head_d  = next_word(head_q);
          end else if (!i_flush && !miss) begin
            fifo_push = 1'b1;
          end
        end else if (i_flush || miss) begin
          state_d = IMPF_DISCARD;
        end
      end
      IMPF_DISCARD: begin
        if (i_mem_ready) begin
          state_d   = IMPF_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = IMPF_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IMPF_IDLE;
      head_q     <= PC_RESET;
      stream_q   <= 1'b1;
      ready_q    <= 1'b0;
      data_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= PC_RESET;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      stream_q   <= stream_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign o_data     = data_q;
  assign o_ready    = ready_q;
  assign o_mem_req  = mem_req_q;
  assign o_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_im_prefetch.sv
// Bench for im_prefetch: memory responder with variable latency, directed scenarios and
// randomized request streams checked against an address-to-word reference memory.
module tb_im_prefetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        flush = 1'b0;
  logic [31:0] data;
  logic        ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        mem_ready = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned mem_lat = 2;
  int unsigned wcnt = 0;
  logic        req_seen = 1'b0;
  logic [31:0] held_addr = '0;
  logic [31:0] fetch_log[$];

  im_prefetch #(
    .DEPTH    (4),
    .PC_RESET (32'h0)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_req       (req),
    .i_addr      (addr),
    .i_flush     (flush),
    .o_data      (data),
    .o_ready     (ready),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_data  (mem_data),
    .i_mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3 ^ {w[15:0], w[31:16]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory: completes each request after mem_lat sampled cycles, logs every new fetch.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ready = 1'b0;
      wcnt      = 0;
      req_seen  = 1'b0;
    end else begin
      if (mem_req && !req_seen) begin
        fetch_log.push_back(mem_addr);
        held_addr = mem_addr;
      end else if (mem_req && req_seen) begin
        check_eq("mem_addr_stable", mem_addr, held_addr);
      end
      req_seen = mem_req;
      if (mem_ready) begin
        mem_ready = 1'b0;
        wcnt      = 0;
      end else if (mem_req) begin
        wcnt++;
        if (wcnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_data  = mem_word(mem_addr);
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge on which o_ready is observed.
  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    if (ready) @(negedge clk);
    req  = 1'b1;
    addr = a;
    lat  = 0;
    d    = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      lat++;
      if (ready) begin
        d = data;
        break;
      end
    end
    if (!ready) check_eq("read_timeout", {31'b0, ready}, 32'h1);
    req = 1'b0;
  endtask

  task automatic wait_mem_req();
    for (int i = 0; i < 60; i++) begin
      if (mem_req) break;
      @(negedge clk);
    end
    check_eq("mem_req_wait", {31'b0, mem_req}, 32'h1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a);
    logic [31:0] d;
    int          l;
    cpu_read(a, d, l);
    check_eq(tag, d, mem_word(a));
  endtask

  initial begin
    logic [31:0] d;
    int          l;
    int          n0;
    logic [31:0] last;
    logic [31:0] a;

    // Reset state.
    wait_cycles(3);
    check_eq("rst_ready", {31'b0, ready}, 32'h0);
    check_eq("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_data", data, 32'h0);

    // Cold miss at 0x0 with 2-cycle memory, then the buffer fills and stops.
    rst_n = 1'b1;
    cpu_read(32'h0, d, l);
    check_eq("cold_data", d, mem_word(32'h0));
    check_eq("cold_latency", l, 3);
    check_eq("cold_addr", fetch_log[0], 32'h0);
    wait_cycles(30);
    check_eq("fill_count", fetch_log.size(), 5);
    for (int i = 1; i < 5; i++) check_eq("fill_addr", fetch_log[i], 32'(i * 4));
    check_eq("full_no_req", {31'b0, mem_req}, 32'h0);

    // Sequential hits from a full buffer.
    for (int i = 1; i <= 4; i++) begin
      cpu_read(32'(i * 4), d, l);
      check_eq("seq_data", d, mem_word(32'(i * 4)));
      check_eq("seq_latency", l, 1);
    end
    wait_cycles(2);
    check_eq("refill_addr", fetch_log[5], 32'h14);

    // Redirect while a prefetch is in flight.
    mem_lat = 6;
    wait_mem_req();
    n0 = fetch_log.size();
    cpu_read(32'h100, d, l);
    check_eq("redirect_data", d, mem_word(32'h100));
    check_eq("redirect_addr", fetch_log[n0], 32'h100);

    // Streaming with single-cycle memory exercises simultaneous push and pop.
    mem_lat = 1;
    for (int i = 0; i < 8; i++) rd_chk("stream_data", 32'h400 + 32'(i * 4));

    // Flush during a fetch: no restart until the next request, no stale word.
    mem_lat = 5;
    wait_mem_req();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n0 = fetch_log.size();
    wait_cycles(15);
    check_eq("flush_no_restart", fetch_log.size(), n0);
    check_eq("flush_idle", {31'b0, mem_req}, 32'h0);
    cpu_read(32'h8, d, l);
    check_eq("flush_data", d, mem_word(32'h8));
    check_eq("flush_refetch", fetch_log[n0], 32'h8);

    // Address wrap at the top of memory.
    mem_lat = 1;
    wait_cycles(40);
    n0 = fetch_log.size();
    rd_chk("wrap_data0", 32'hFFFF_FFF8);
    wait_cycles(10);
    check_eq("wrap_a0", fetch_log[n0], 32'hFFFF_FFF8);
    check_eq("wrap_a1", fetch_log[n0 + 1], 32'hFFFF_FFFC);
    check_eq("wrap_a2", fetch_log[n0 + 2], 32'h0);
    rd_chk("wrap_data1", 32'hFFFF_FFFC);
    cpu_read(32'h0, d, l);
    check_eq("wrap_data2", d, mem_word(32'h0));
    check_eq("wrap_latency", l, 1);

    // Asynchronous reset in the middle of a fetch.
    mem_lat = 5;
    req  = 1'b1;
    addr = 32'h300;
    wait_mem_req();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_mem_req", {31'b0, mem_req}, 32'h0);
    check_eq("arst_ready", {31'b0, ready}, 32'h0);
    check_eq("arst_mem_addr", mem_addr, 32'h0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized streams: mostly sequential, some jumps, unaligned low bits, flushes.
    last = 32'h0;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        if (ready) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
      mem_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 9) < 7) a = last + 32'h4;
      else a = 32'h1000 + 32'($urandom_range(0, 63) * 4);
      cpu_read(a | 32'($urandom_range(0, 3)), d, l);
      check_eq("rnd_data", d, mem_word(a));
      last = a;
    end

    wait_cycles(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
